// File: rtl/fex7_sequencer.sv
// Factorial-base (radices 2..8) value sequencer with a valid/ready output and a
// programmable step period; inc7fex supplies the combinational increment.

module inc7fex (
    input  logic [16:0] cur,
    output logic [16:0] nxt,
    output logic        at_max
);
    logic       f1, n1;
    logic [1:0] f2, f3, n2, n3;
    logic [2:0] f4, f5, f6, f7, n4, n5, n6, n7;
    logic       c2, c3, c4, c5, c6, c7;

    always_comb begin
        f1 = cur[0];
        f2 = cur[2:1];
        f3 = cur[4:3];
        f4 = cur[7:5];
        f5 = cur[10:8];
        f6 = cur[13:11];
        f7 = cur[16:14];

        // ck: every digit below k sits at its maximum, so digit k advances
        c2     = (f1 == 1'b1);
        c3     = c2 && (f2 == 2'd2);
        c4     = c3 && (f3 == 2'd3);
        c5     = c4 && (f4 == 3'd4);
        c6     = c5 && (f5 == 3'd5);
        c7     = c6 && (f6 == 3'd6);
        at_max = c7 && (f7 == 3'd7);

        n1 = ~f1;
        n2 = !c2 ? f2 : ((f2 == 2'd2) ? 2'd0 : f2 + 2'd1);
        n3 = !c3 ? f3 : ((f3 == 2'd3) ? 2'd0 : f3 + 2'd1);
        n4 = !c4 ? f4 : ((f4 == 3'd4) ? 3'd0 : f4 + 3'd1);
        n5 = !c5 ? f5 : ((f5 == 3'd5) ? 3'd0 : f5 + 3'd1);
        n6 = !c6 ? f6 : ((f6 == 3'd6) ? 3'd0 : f6 + 3'd1);
        n7 = !c7 ? f7 : ((f7 == 3'd7) ? 3'd0 : f7 + 3'd1);

        nxt = {n7, n6, n5, n4, n3, n2, n1};
    end
endmodule

module fex7_sequencer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             one_shot,
    input  logic             load,
    input  logic [16:0]      load_digits,
    input  logic [DIV_W-1:0] period,
    output logic [16:0]      digits,
    output logic             valid,
    input  logic             ready,
    output logic             wrap,
    output logic             done,
    output logic             load_err,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [16:0]      digits_q, digits_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             one_shot_q, one_shot_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             load_err_q, load_err_d;

    logic [16:0]      inc_digits;
    logic             inc_at_max;
    logic             accept;
    logic             load_legal;
    logic [DIV_W-1:0] presc_reload;

    inc7fex u_inc (
        .cur    (digits_q),
        .nxt    (inc_digits),
        .at_max (inc_at_max)
    );

    // Handshake: valid holds with digits frozen until a cycle where valid and
    // ready are both high; that rising edge is the single transfer point.
    assign accept = (state_q == S_PRESENT) && ready;

    assign load_legal = (load_digits[2:1]   <= 2'd2) &&
                        (load_digits[7:5]   <= 3'd4) &&
                        (load_digits[10:8]  <= 3'd5) &&
                        (load_digits[13:11] <= 3'd6);

    // A zero period behaves as one: valid returns on the first edge after WAIT.
    assign presc_reload = (period == '0) ? '0 : period - {{(DIV_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            digits_q   <= '0;
            presc_q    <= '0;
            one_shot_q <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            presc_q    <= presc_d;
            one_shot_q <= one_shot_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        presc_d    = presc_q;
        one_shot_d = one_shot_q;
        load_err_d = load_err_q;
        wrap_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    if (load_legal) begin
                        digits_d   = load_digits;
                        load_err_d = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (start && !stop) begin
                    state_d    = S_PRESENT;
                    one_shot_d = one_shot;
                end
            end

            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (presc_q == '0) begin
                    state_d = S_PRESENT;
                end else begin
                    presc_d = presc_q - {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end

            S_PRESENT: begin
                if (accept) begin
                    digits_d = inc_digits;
                    presc_d  = presc_reload;
                    wrap_d   = inc_at_max;
                    done_d   = inc_at_max && one_shot_q;
                    if (stop || (inc_at_max && one_shot_q)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (stop) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign digits    = digits_q;
    assign valid     = (state_q == S_PRESENT);
    assign busy      = (state_q != S_IDLE);
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_fex7_sequencer.sv
// Bench for fex7_sequencer: directed scenarios plus randomized traffic, checked
// every cycle against a value-index model of the sequencer.

module tb_fex7_sequencer;
    localparam int DIV_W = 16;
    localparam int FULL  = 40320;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             one_shot = 1'b0;
    logic             load = 1'b0;
    logic [16:0]      load_digits = '0;
    logic [DIV_W-1:0] period = 16'd1;
    logic             ready = 1'b0;
    logic [16:0]      digits;
    logic             valid, wrap, done, load_err, busy;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    fex7_sequencer #(.DIV_W(DIV_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .one_shot    (one_shot),
        .load        (load),
        .load_digits (load_digits),
        .period      (period),
        .digits      (digits),
        .valid       (valid),
        .ready       (ready),
        .wrap        (wrap),
        .done        (done),
        .load_err    (load_err),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mixed-radix conversion between a value index and the packed digit word.
    function automatic logic [16:0] to_packed(input int idx);
        logic [16:0] p;
        p[0]     = 1'(idx % 2);
        p[2:1]   = 2'((idx / 2) % 3);
        p[4:3]   = 2'((idx / 6) % 4);
        p[7:5]   = 3'((idx / 24) % 5);
        p[10:8]  = 3'((idx / 120) % 6);
        p[13:11] = 3'((idx / 720) % 7);
        p[16:14] = 3'((idx / 5040) % 8);
        return p;
    endfunction

    function automatic int to_idx(input logic [16:0] p);
        return int'(p[0]) + 2 * int'(p[2:1]) + 6 * int'(p[4:3]) + 24 * int'(p[7:5]) +
               120 * int'(p[10:8]) + 720 * int'(p[13:11]) + 5040 * int'(p[16:14]);
    endfunction

    function automatic bit is_legal(input logic [16:0] p);
        return (p[2:1] <= 2) && (p[7:5] <= 4) && (p[10:8] <= 5) && (p[13:11] <= 6);
    endfunction

    // Reference model: the value is an integer index; timing is a countdown of
    // cycles until the next presentation.
    bit m_run = 0, m_valid = 0, m_os = 0, m_wrap = 0, m_done = 0, m_err = 0;
    int m_idx = 0, m_wait = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_valid = 0; m_os = 0; m_wrap = 0; m_done = 0; m_err = 0;
            m_idx = 0; m_wait = 0;
        end else begin
            m_wrap = 0;
            m_done = 0;
            if (!m_run) begin
                if (load) begin
                    if (is_legal(load_digits)) begin
                        m_idx = to_idx(load_digits);
                        m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end else if (start && !stop) begin
                    m_run = 1; m_valid = 1; m_os = one_shot;
                end
            end else if (m_valid) begin
                if (ready) begin
                    m_wrap  = (m_idx == FULL - 1);
                    m_done  = m_wrap && m_os;
                    m_idx   = (m_idx + 1) % FULL;
                    m_valid = 0;
                    m_wait  = (period == 0) ? 1 : int'(period);
                    if (stop || m_done) m_run = 0;
                end else if (stop) begin
                    m_run = 0; m_valid = 0;
                end
            end else begin
                if (stop) begin
                    m_run = 0;
                end else begin
                    m_wait--;
                    if (m_wait == 0) m_valid = 1;
                end
            end
        end
    end

    bit          cmp_en = 0;
    logic [16:0] acc_q[$];
    logic [16:0] exp_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("digits", 32'(digits), 32'(to_packed(m_idx)));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_run));
            chk("wrap", 32'(wrap), 32'(m_wrap));
            chk("done", 32'(done), 32'(m_done));
            chk("load_err", 32'(load_err), 32'(m_err));
            if (valid && ready) acc_q.push_back(digits);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic do_load(input logic [16:0] v);
        load = 1'b1;
        load_digits = v;
        tick(1);
        load = 1'b0;
    endtask

    task automatic do_start(input logic os);
        one_shot = os;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] bad;
        int n, both, first_wrap;

        tick(1);
        cmp_en = 1;
        do_reset();

        // Model pinned against hand-derived packings.
        chk("pin_idx6", 32'(to_packed(6)), 32'h8);
        chk("pin_max", 32'(to_packed(FULL - 1)), 32'h1F59D);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Free-running count from zero, period 1.
        period = 16'd1; ready = 1'b1;
        acc_q.delete();
        do_start(1'b0);
        for (int i = 0; i < 40 && acc_q.size() < 4; i++) tick(1);
        ready = 1'b0;
        chk("seq_count", 32'(acc_q.size()), 32'd4);
        exp_q = '{17'd0, 17'd1, 17'd2, 17'd3};
        while (exp_q.size() > 0 && acc_q.size() > 0)
            chk("seq_value", 32'(acc_q.pop_front()), 32'(exp_q.pop_front()));
        tick(1);
        stop = 1'b1; start = 1'b1;
        tick(1);
        stop = 1'b0; start = 1'b0;
        tick(2);
        chk("stop_digits", 32'(digits), 32'd4);
        chk("stop_valid", 32'(valid), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);

        // One-shot from the all-maximum value.
        do_load(17'h1F59D);
        acc_q.delete();
        ready = 1'b1;
        do_start(1'b1);
        both = 0;
        for (int i = 0; i < 10; i++) begin
            if (wrap && done) both++;
            tick(1);
        end
        ready = 1'b0;
        chk("os_accepts", 32'(acc_q.size()), 32'd1);
        chk("os_wrap_done", 32'(both), 32'd1);
        chk("os_digits", 32'(digits), 32'd0);
        chk("os_busy", 32'(busy), 32'd0);

        // Illegal then legal load.
        bad = 17'h1F59D;
        bad[13:11] = 3'd7;
        do_load(bad);
        chk("bad_load_err", 32'(load_err), 32'd1);
        chk("bad_load_digits", 32'(digits), 32'd0);
        do_load(17'd5);
        chk("good_load_err", 32'(load_err), 32'd0);
        chk("good_load_digits", 32'(digits), 32'd5);

        // Back-pressure and period 5.
        period = 16'd5;
        do_start(1'b0);
        tick(10);
        chk("bp_valid", 32'(valid), 32'd1);
        chk("bp_digits", 32'(digits), 32'd5);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        n = 0;
        while (!valid && n < 50) begin
            tick(1);
            n++;
        end
        chk("period5_gap", 32'(n), 32'd5);
        chk("period5_digits", 32'(digits), 32'd8);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;

        // Reset in the middle of a long wait.
        period = 16'd20; ready = 1'b1;
        do_start(1'b0);
        tick(1);
        ready = 1'b0;
        tick(2);
        chk("midwait_busy", 32'(busy), 32'd1);
        do_reset();
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick(5);
        chk("rst_no_valid", 32'(valid), 32'd0);

        // Acceptances up to the wrap pulse from a late starting value.
        period = 16'd1; ready = 1'b1;
        do_load(to_packed(FULL - 10));
        acc_q.delete();
        do_start(1'b0);
        first_wrap = 0;
        for (int i = 0; i < 100 && !first_wrap; i++) begin
            if (wrap) first_wrap = 1;
            else tick(1);
        end
        chk("wrap_seen", 32'(first_wrap), 32'd1);
        chk("wrap_accepts", 32'(acc_q.size()), 32'd10);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            ready    = ($urandom_range(0, 3) != 0);
            stop     = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 7) == 0);
            one_shot = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 15) == 0);
            period   = 16'($urandom_range(0, 4));
            case ($urandom_range(0, 2))
                0: load_digits = to_packed($urandom_range(0, FULL - 1));
                1: load_digits = to_packed(FULL - 1 - $urandom_range(0, 6));
                default: load_digits = 17'($urandom);
            endcase
            if ($urandom_range(0, 599) == 0) reset_n = 1'b0;
            tick(1);
            reset_n = 1'b1;
        end
        start = 1'b0; load = 1'b0; stop = 1'b1;
        tick(2);
        stop = 1'b0;
        tick(2);
        cmp_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
